// File: rtl/adc_rst_seq.sv
// adc_rst_seq: power-up reset sequencer for the ADC capture path.
// It waits for a stable PLL lock, pulses the ADC reset pin, waits out the ADC
// wake-up time, then releases the IO reset and finally the core reset.
// The sequence re-runs on loss of lock or on a software restart.
module adc_rst_seq #(
  parameter int CNT_W       = 16,
  parameter int LOCK_STABLE = 256,
  parameter int ADC_RST_LEN = 64,
  parameter int ADC_WAKE    = 1024,
  parameter int IO_SETTLE   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       adc_rst,
  output logic       io_rst_n,
  output logic       core_rst_n,
  output logic       seq_done,
  output logic [2:0] seq_state,
  output logic [7:0] relock_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOCK   = 3'd1;
  localparam logic [2:0] S_ADCRST = 3'd2;
  localparam logic [2:0] S_WAKE   = 3'd3;
  localparam logic [2:0] S_IO     = 3'd4;
  localparam logic [2:0] S_RUN    = 3'd5;

  // Every delay must fit the shared counter and be at least one cycle.
  localparam int MAX_DLY = (1 << CNT_W) - 1;
  localparam logic [3:0][31:0] DELAYS = {32'(LOCK_STABLE), 32'(ADC_RST_LEN),
                                         32'(ADC_WAKE), 32'(IO_SETTLE)};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dly_chk
      if (DELAYS[gi] < 32'd1 || DELAYS[gi] > 32'(MAX_DLY)) begin : g_bad
        $error("adc_rst_seq: delay parameter %0d out of range", gi);
      end
    end
  endgenerate

  // Terminal counts: a state of delay N exits when the counter reads N-1.
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] ARST_LAST = CNT_W'(ADC_RST_LEN - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(ADC_WAKE - 1);
  localparam logic [CNT_W-1:0] IO_LAST   = CNT_W'(IO_SETTLE - 1);

  logic             sync_meta_reg;
  logic             locked_s;
  logic [2:0]       state_reg;
  logic [2:0]       state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             abort;
  logic             past_lock;

  assign seq_state = state_reg;
  assign past_lock = (state_reg == S_ADCRST) || (state_reg == S_WAKE) ||
                     (state_reg == S_IO) || (state_reg == S_RUN);

  // Two-flop synchronizer bringing the asynchronous PLL lock into clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta_reg <= 1'b0;
      locked_s      <= 1'b0;
    end else begin
      sync_meta_reg <= pll_locked;
      locked_s      <= sync_meta_reg;
    end
  end

  // Next-state logic; restart overrides lock loss, which overrides timing.
  always_comb begin
    state_next = state_reg;
    abort      = 1'b0;
    case (state_reg)
      S_IDLE:   state_next = S_LOCK;
      S_LOCK:   if (locked_s && cnt_reg == LOCK_LAST) state_next = S_ADCRST;
      S_ADCRST: if (cnt_reg == ARST_LAST) state_next = S_WAKE;
      S_WAKE:   if (cnt_reg == WAKE_LAST) state_next = S_IO;
      S_IO:     if (cnt_reg == IO_LAST) state_next = S_RUN;
      S_RUN:    state_next = S_RUN;
      default:  state_next = S_IDLE;
    endcase
    if (past_lock && !locked_s) begin
      state_next = S_LOCK;
      abort      = 1'b1;
    end
    if (restart && state_reg != S_IDLE) begin
      state_next = S_IDLE;
      abort      = 1'b0;
    end
  end

  // Shared delay counter: cleared on any state change; in S_LOCK it counts
  // only an unbroken run of locked cycles.
  always_comb begin
    cnt_next = cnt_reg;
    if (state_next != state_reg) begin
      cnt_next = '0;
    end else if (state_reg == S_LOCK) begin
      cnt_next = locked_s ? cnt_reg + CNT_W'(1) : '0;
    end else if (state_reg == S_ADCRST || state_reg == S_WAKE || state_reg == S_IO) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end else begin
      cnt_next = '0;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Reset outputs decoded from the next state so they move with seq_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_rst    <= 1'b1;
      io_rst_n   <= 1'b0;
      core_rst_n <= 1'b0;
      seq_done   <= 1'b0;
    end else begin
      adc_rst    <= (state_next == S_IDLE) || (state_next == S_LOCK) ||
                    (state_next == S_ADCRST);
      io_rst_n   <= (state_next == S_IO) || (state_next == S_RUN);
      core_rst_n <= (state_next == S_RUN);
      seq_done   <= (state_next == S_RUN);
    end
  end

  // Saturating count of lock-loss aborts, cleared only by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      relock_cnt <= 8'd0;
    end else if (abort && relock_cnt != 8'hFF) begin
      relock_cnt <= relock_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_adc_rst_seq.sv
// tb_adc_rst_seq: directed bench for the ADC reset sequencer using short delays
// (LOCK_STABLE=4, ADC_RST_LEN=3, ADC_WAKE=5, IO_SETTLE=2).
module tb_adc_rst_seq;

  logic       clk;
  logic       rst_n;
  logic       pll_locked;
  logic       restart;
  logic       adc_rst;
  logic       io_rst_n;
  logic       core_rst_n;
  logic       seq_done;
  logic [2:0] seq_state;
  logic [7:0] relock_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  adc_rst_seq #(
    .CNT_W(16), .LOCK_STABLE(4), .ADC_RST_LEN(3), .ADC_WAKE(5), .IO_SETTLE(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .restart(restart),
    .adc_rst(adc_rst), .io_rst_n(io_rst_n), .core_rst_n(core_rst_n),
    .seq_done(seq_done), .seq_state(seq_state), .relock_cnt(relock_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports mismatches.
  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", tag, got, exp);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-derived nominal timeline: state after edge n, where edge 2 starts L.
  // LOCK L..L+3, ADCRST L+4..L+6, WAKE L+7..L+11, IO L+12..13, RUN from L+14.
  function automatic int exp_nom(input int n);
    if (n <= 5) return 1;
    else if (n <= 8) return 2;
    else if (n <= 13) return 3;
    else if (n <= 15) return 4;
    else return 5;
  endfunction

  task automatic walk(input string tag, input int first, input int last);
    int s;
    for (int n = first; n <= last; n++) begin
      tick();
      s = exp_nom(n);
      check_eq($sformatf("%s_state_e%0d", tag, n), int'(seq_state), s);
      check_eq($sformatf("%s_adc_rst_e%0d", tag, n), int'(adc_rst), (s <= 2) ? 1 : 0);
      check_eq($sformatf("%s_io_rst_n_e%0d", tag, n), int'(io_rst_n), (s >= 4) ? 1 : 0);
      check_eq($sformatf("%s_core_rst_n_e%0d", tag, n), int'(core_rst_n), (s == 5) ? 1 : 0);
      check_eq($sformatf("%s_seq_done_e%0d", tag, n), int'(seq_done), (s == 5) ? 1 : 0);
    end
  endtask

  // Bounded wait for a state; an expired budget shows up as a failed check.
  task automatic wait_state(input string tag, input int s, input int max_cyc);
    for (int k = 0; k < max_cyc; k++) begin
      tick();
      if (int'(seq_state) == s) break;
    end
    check_eq(tag, int'(seq_state), s);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_state"}, int'(seq_state), 0);
    check_eq({tag, "_adc_rst"}, int'(adc_rst), 1);
    check_eq({tag, "_io_rst_n"}, int'(io_rst_n), 0);
    check_eq({tag, "_core_rst_n"}, int'(core_rst_n), 0);
    check_eq({tag, "_seq_done"}, int'(seq_done), 0);
    check_eq({tag, "_relock"}, int'(relock_cnt), 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b1;
    restart    = 1'b0;
    tick();
    tick();
    check_reset_vals("rst");

    // Nominal power-up with lock held high.
    rst_n = 1'b1;
    walk("nom", 1, 18);
    check_eq("nom_relock", int'(relock_cnt), 0);
    $display("scenario nominal: state=%0d relock=%0d", seq_state, relock_cnt);

    // Lock loss in S_RUN: resets reassert three edges after the fall.
    pll_locked = 1'b0;
    tick();
    check_eq("ll_e1_state", int'(seq_state), 5);
    tick();
    check_eq("ll_e2_core_rst_n", int'(core_rst_n), 1);
    tick();
    check_eq("ll_e3_state", int'(seq_state), 1);
    check_eq("ll_e3_core_rst_n", int'(core_rst_n), 0);
    check_eq("ll_e3_io_rst_n", int'(io_rst_n), 0);
    check_eq("ll_e3_adc_rst", int'(adc_rst), 1);
    check_eq("ll_e3_relock", int'(relock_cnt), 1);
    pll_locked = 1'b1;
    walk("relock", 1, 18);
    check_eq("relock_cnt_after", int'(relock_cnt), 1);
    $display("scenario lock loss: state=%0d relock=%0d", seq_state, relock_cnt);

    // Restart from S_RUN, walk into S_WAKE, then restart there.
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check_eq("rs_run_state", int'(seq_state), 0);
    walk("rs", 2, 10);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check_eq("rs_wake_state", int'(seq_state), 0);
    check_eq("rs_wake_io_rst_n", int'(io_rst_n), 0);
    check_eq("rs_wake_relock", int'(relock_cnt), 1);
    walk("rs2", 2, 18);
    check_eq("rs2_relock", int'(relock_cnt), 1);
    $display("scenario restart: state=%0d relock=%0d", seq_state, relock_cnt);

    // Restart coincident with lock loss: restart wins, no abort counted.
    pll_locked = 1'b0;
    tick();
    tick();
    check_eq("combo_pre_state", int'(seq_state), 5);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check_eq("combo_state", int'(seq_state), 0);
    check_eq("combo_relock", int'(relock_cnt), 1);
    pll_locked = 1'b1;
    $display("scenario restart+lockloss: state=%0d relock=%0d", seq_state, relock_cnt);

    // Lock glitch in S_LOCK from a fresh reset.
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    #1;
    check_reset_vals("glitch_rst");
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    pll_locked = 1'b1;
    tick();
    tick();
    tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    for (int n = 7; n <= 11; n++) begin
      tick();
      check_eq($sformatf("glitch_hold_e%0d", n), int'(seq_state), 1);
    end
    tick();
    check_eq("glitch_exit_e12", int'(seq_state), 2);
    $display("scenario lock glitch: state=%0d", seq_state);

    // Saturation of the abort counter.
    for (int i = 0; i < 300; i++) begin
      wait_state("sat_up", 2, 40);
      pll_locked = 1'b0;
      wait_state("sat_dn", 1, 10);
      pll_locked = 1'b1;
      if (i == 9) check_eq("sat_relock_10", int'(relock_cnt), 10);
    end
    check_eq("sat_relock_255", int'(relock_cnt), 255);
    wait_state("sat_up_extra", 2, 40);
    pll_locked = 1'b0;
    wait_state("sat_dn_extra", 1, 10);
    pll_locked = 1'b1;
    check_eq("sat_relock_hold", int'(relock_cnt), 255);
    $display("scenario saturation: relock=%0d", relock_cnt);

    // Asynchronous reset between edges while in S_IO.
    wait_state("ar_reach_io", 4, 40);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("ar");
    tick();
    check_eq("ar_hold_state", int'(seq_state), 0);
    rst_n = 1'b1;
    $display("scenario async reset: state=%0d relock=%0d", seq_state, relock_cnt);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
